mram_burst_sequencer: RTL
=========================

// Module: mram_burst_sequencer
// PURPOSE
//  Burst-level controller for the serial MRAM access path. Accepts a burst command (start address,
//  length, direction) from a host, then per word shifts address/write-data bits serially into the MRAM
//  top module, issues its read/write select command, waits out the access, and de-serialises read data.
//  Sits between host logic and the MRAM top module's addr_in/data_in/read_write_sel/ser_data_out pins.
// PARAMETERS
//  ADDR_W        20      address width; serial address shift length
//  DATA_W        16      word width; serial data shift length (DATA_W <= ADDR_W)
//  LEN_W         8       burst length field width; req_len encodes (words-1)
//  ACCESS_CYCLES 4       idle cycles after command before next shift/capture (>=1)
//  CMD_IDLE      3'b000  rw_sel value when no command is issued
//  CMD_WRITE     3'b001  rw_sel value for a one-word write
//  CMD_READ      3'b010  rw_sel value for a one-word read
// PORTS
//  clk          in   1       single clock, all logic rising-edge
//  rst          in   1       asynchronous, active-low reset
//  req_valid    in   1       burst request valid
//  req_ready    out  1       high only in IDLE; transfer when req_valid&req_ready
//  req_write    in   1       1 = write burst, 0 = read burst
//  req_addr     in   ADDR_W  first word address
//  req_len      in   LEN_W   words-1 (0 -> 1 word, 255 -> 256 words)
//  wr_data      in   DATA_W  write word; wr_valid/wr_ready handshake
//  wr_valid     in   1       write word valid
//  wr_ready     out  1       high in LOAD state of a write burst
//  rd_data      out  DATA_W  captured read word; held stable while rd_valid
//  rd_valid     out  1       read word available
//  rd_ready     in   1       host accepts read word
//  ser_addr     out  1       to MRAM top addr_in, MSB first
//  ser_data     out  1       to MRAM top data_in, MSB first
//  rw_sel       out  3       to MRAM top read_write_sel
//  ser_rd_data  in   1       from MRAM top ser_data_out, MSB first
//  busy         out  1       high whenever state != IDLE
//  done         out  1       one-cycle pulse when the last word of a burst completes
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; req_ready=1 after release; wr_ready, rd_valid, busy, done,
//   ser_addr, ser_data = 0; rw_sel = CMD_IDLE; rd_data, addr/count/shift registers = 0.
//  States: IDLE -> (req accepted) LOAD -> SHIFT -> CMD -> WAIT -> [read: CAPTURE -> DELIVER] -> NEXT.
//  IDLE: latch req_addr, req_len, req_write on handshake; next LOAD.
//  LOAD: write: wait for wr_valid (stall indefinitely, outputs held 0/CMD_IDLE); latch wr_data on
//   wr_valid&wr_ready. Read: single cycle. Next SHIFT.
//  SHIFT: exactly ADDR_W cycles; ser_addr = addr bit ADDR_W-1..0. ser_data = 0 for first ADDR_W-DATA_W
//   cycles, then data bit DATA_W-1..0, so last address and data bits leave in the same cycle.
//  CMD: one cycle, rw_sel = CMD_WRITE or CMD_READ; ser_addr/ser_data = 0. rw_sel = CMD_IDLE elsewhere.
//  WAIT: ACCESS_CYCLES cycles; then write -> NEXT, read -> CAPTURE.
//  CAPTURE: DATA_W cycles sampling ser_rd_data into shift register MSB first; then DELIVER.
//  DELIVER: rd_valid=1, rd_data stable until rd_ready; on rd_valid&rd_ready -> NEXT.
//  NEXT: if word count == req_len: done=1 for this cycle, -> IDLE; else addr+1, count+1, -> LOAD.
//  Address increment wraps modulo 2^ADDR_W (0xFFFFF -> 0x00000), no error.
//  Per-word latency (no stalls): write 1+ADDR_W+1+ACCESS_CYCLES+1; read adds DATA_W+1 before NEXT.
//  req_valid while busy is ignored (req_ready=0); wr_valid outside LOAD is ignored.
//  Reset mid-burst aborts immediately; no partial done pulse; MRAM side left with rw_sel = CMD_IDLE.
// CONFIGURATION
//  MRAM_SEQ_ABORT_EN defined: adds input abort (1 bit). abort sampled in NEXT (or while stalled in
//   LOAD): burst ends after the current word, done=1 for one cycle, -> IDLE; extra output aborted
//   (1 bit) high with done, cleared on next req accept. Abort in LOAD skips the pending word.
//  Not defined: no abort/aborted ports; every accepted burst runs to req_len+1 words.
// TESTING
//  Write burst addr=0x00010 len=0 data=0xA5C3 -> ser_addr shifts 0x00010, ser_data's last 16 bits
//   0xA5C3, rw_sel=CMD_WRITE one cycle, done at cycle 1+20+1+4+1 after LOAD entry.
//  Read burst addr=0x00200 len=3, model returns addr[15:0]^0xFFFF -> rd_data 0xFDFF,0xFDFE,0xFDFD,
//   0xFDFC in order, one done pulse after 4th accept.
//  Wrap: write burst addr=0xFFFFF len=1 -> second word shifted at address 0x00000.
//  Backpressure: hold wr_valid low 10 cycles in LOAD, rd_ready low 7 cycles in DELIVER -> no shift,
//   rw_sel stays CMD_IDLE, rd_data constant, burst completes correctly after release.
//  Reset asserted mid-SHIFT of word 2 of a len=4 burst -> all outputs to reset values immediately,
//   busy=0, no done; new request accepted after release.
//  MRAM_SEQ_ABORT_EN: abort pulsed during word 1 of a len=7 read -> 2 words delivered, done and
//   aborted high together, req_ready=1 next cycle.

Source files
------------

// File: rtl/mram_burst_sequencer_if.sv
// Host-side bus of the MRAM burst sequencer.
// Groups the burst request, write-word and read-word handshakes.
//   master : host logic (drives requests and write words, accepts read words)
//   slave  : mram_burst_sequencer
interface mram_burst_sequencer_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;

  modport master (
    output req_valid, req_write, req_addr, req_len, wr_data, wr_valid, rd_ready,
    input  req_ready, wr_ready, rd_data, rd_valid
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, wr_data, wr_valid, rd_ready,
    output req_ready, wr_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/mram_burst_sequencer.sv
// Burst-level controller for the serial MRAM access path.
// Accepts a burst command from the host, then for every word shifts the
// address (and write data) serially into the MRAM top, issues the one-cycle
// read/write select, waits out the access and de-serialises read data.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   host         mram_burst_sequencer_if.slave (req_*, wr_*, rd_* handshakes)
//   ser_addr     serial address to MRAM addr_in, MSB first
//   ser_data     serial write data to MRAM data_in, MSB first
//   rw_sel       command to MRAM read_write_sel (CMD_IDLE when not issuing)
//   ser_rd_data  serial read data from MRAM ser_data_out, MSB first
//   busy         high whenever the sequencer is not idle
//   done         one-cycle pulse when a burst finishes
//   abort        (MRAM_SEQ_ABORT_EN only) end the burst after the current word
//   aborted      (MRAM_SEQ_ABORT_EN only) burst ended by abort; cleared on next accept
//
// Optional feature: define MRAM_SEQ_ABORT_EN to add the abort/aborted ports.
module mram_burst_sequencer #(
  parameter int          ADDR_W        = 20,
  parameter int          DATA_W        = 16,
  parameter int          LEN_W         = 8,
  parameter int          ACCESS_CYCLES = 4,
  parameter logic [2:0]  CMD_IDLE      = 3'b000,
  parameter logic [2:0]  CMD_WRITE     = 3'b001,
  parameter logic [2:0]  CMD_READ      = 3'b010
) (
  input  logic                  clk,
  input  logic                  rst,
  mram_burst_sequencer_if.slave host,
  output logic                  ser_addr,
  output logic                  ser_data,
  output logic [2:0]            rw_sel,
  input  logic                  ser_rd_data,
  output logic                  busy,
  output logic                  done
`ifdef MRAM_SEQ_ABORT_EN
  ,
  input  logic                  abort,
  output logic                  aborted
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_CMD     = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_CAPTURE = 3'd5;
  localparam logic [2:0] S_DELIVER = 3'd6;
  localparam logic [2:0] S_NEXT    = 3'd7;

  // One shared cycle counter covers SHIFT, WAIT and CAPTURE.
  localparam int CNT_MAX = (ADDR_W > ACCESS_CYCLES) ? ADDR_W : ACCESS_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] PAD_CYC    = CNT_W'(ADDR_W - DATA_W);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(DATA_W - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_sh;
  logic [DATA_W-1:0] data_sh;
  logic [DATA_W-1:0] rd_sh;
  logic [CNT_W-1:0]  cyc_q;

  logic last_word;
  logic data_phase;
  logic abort_next;
  logic abort_load;

  assign last_word  = (cnt_q == len_q);
  // Data is right-aligned to the address so the final bits leave together.
  assign data_phase = (cyc_q >= PAD_CYC);

`ifdef MRAM_SEQ_ABORT_EN
  logic aborted_q;

  assign abort_next = (state == S_NEXT) && abort;
  // Only a write stalled waiting for its word can be aborted from LOAD.
  assign abort_load = (state == S_LOAD) && write_q && !host.wr_valid && abort;
  assign aborted    = aborted_q || abort_next || abort_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aborted_q <= 1'b0;
    end else if (host.req_valid && (state == S_IDLE)) begin
      aborted_q <= 1'b0;
    end else if (abort_next || abort_load) begin
      aborted_q <= 1'b1;
    end
  end
`else
  assign abort_next = 1'b0;
  assign abort_load = 1'b0;
`endif

  assign host.req_ready = (state == S_IDLE);
  assign host.wr_ready  = (state == S_LOAD) && write_q;
  assign host.rd_valid  = (state == S_DELIVER);
  assign host.rd_data   = rd_sh;
  assign busy           = (state != S_IDLE);
  assign done           = ((state == S_NEXT) && last_word) || abort_next || abort_load;
  assign ser_addr       = (state == S_SHIFT) && addr_sh[ADDR_W-1];
  assign ser_data       = (state == S_SHIFT) && data_phase && data_sh[DATA_W-1];
  assign rw_sel         = (state != S_CMD) ? CMD_IDLE : (write_q ? CMD_WRITE : CMD_READ);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_sh <= '0;
      data_sh <= '0;
      rd_sh   <= '0;
      cyc_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (host.req_valid) begin
            addr_q  <= host.req_addr;
            len_q   <= host.req_len;
            write_q <= host.req_write;
            cnt_q   <= '0;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          addr_sh <= addr_q;
          cyc_q   <= '0;
          if (!write_q) begin
            data_sh <= '0;
            state   <= S_SHIFT;
          end else if (host.wr_valid) begin
            data_sh <= host.wr_data;
            state   <= S_SHIFT;
          end else if (abort_load) begin
            state   <= S_IDLE;
          end
        end
        S_SHIFT: begin
          addr_sh <= addr_sh << 1;
          if (data_phase) data_sh <= data_sh << 1;
          if (cyc_q == SHIFT_LAST) begin
            cyc_q <= '0;
            state <= S_CMD;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        S_CMD: begin
          cyc_q <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cyc_q == WAIT_LAST) begin
            cyc_q <= '0;
            state <= write_q ? S_NEXT : S_CAPTURE;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        S_CAPTURE: begin
          rd_sh <= {rd_sh[DATA_W-2:0], ser_rd_data};
          if (cyc_q == CAP_LAST) begin
            cyc_q <= '0;
            state <= S_DELIVER;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        S_DELIVER: begin
          if (host.rd_ready) state <= S_NEXT;
        end
        S_NEXT: begin
          if (last_word || abort_next) begin
            state <= S_IDLE;
          end else begin
            addr_q <= addr_q + 1'b1;
            cnt_q  <= cnt_q + 1'b1;
            state  <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
